johnson_decoder_monitor: RTL and testbench

//  Receive end of a Johnson (twisted-ring) counter bus. Samples an N-bit Johnson code,

---
 rtl/johnson_pkg.sv | 37 +++
 rtl/johnson_code_decode.sv | 31 +++
 rtl/johnson_decoder_monitor.sv | 155 +++++++++++++++
 tb/tb_johnson_decoder_monitor.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/johnson_pkg.sv
// johnson_pkg
//   Shared types and helpers for the Johnson-code receive monitor.
//   - state_t / UNLOCKED / LOCKED : tracking FSM encoding
//   - step_t                      : classification of one sampled step
//   - johnson_legal(code, n)      : 1 when code has at most one adjacent-bit transition
//   - johnson_to_idx(code, n)     : Johnson code to sequence index 0..2n-1
//   Codes are passed zero-extended to MAX_N bits; n selects the live width.
package johnson_pkg;

  typedef logic [0:0] state_t;
  localparam state_t UNLOCKED = 1'b0;
  localparam state_t LOCKED   = 1'b1;

  typedef enum logic [1:0] {HOLD, ADV, RET, SKIP} step_t;

  localparam int MAX_N = 32;

  function automatic logic johnson_legal(input logic [MAX_N-1:0] code, input int n);
    int trans = 0;
    for (int i = 1; i < MAX_N; i++) begin
      if (i < n && code[i] != code[i-1]) trans++;
    end
    return (trans <= 1);
  endfunction

  // Ones fill from the LSB on the way up, then drain from the LSB on the way
  // back down once the MSB is set, so the second half counts zeros.
  function automatic int johnson_to_idx(input logic [MAX_N-1:0] code, input int n);
    int ones = 0;
    for (int i = 0; i < MAX_N; i++) begin
      if (i < n && code[i]) ones++;
    end
    if (code[n-1]) return n + (n - ones);
    return ones;
  endfunction

endpackage

// File: rtl/johnson_code_decode.sv
// johnson_code_decode
//   Purely combinational decode of one Johnson code.
//   Ports:
//     q      in  N     Johnson code
//     legal  out 1     code is a legal Johnson pattern
//     idx    out IW    decoded index (meaningful only when legal)
//     onehot out 2N    one-hot of idx, all zeros when the code is illegal
module johnson_code_decode
  import johnson_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = $clog2(2 * N)
) (
  input  logic [N-1:0]   q,
  output logic           legal,
  output logic [IW-1:0]  idx,
  output logic [2*N-1:0] onehot
);

  logic [MAX_N-1:0] code_ext;

  assign code_ext = MAX_N'(q);

  always_comb begin
    legal  = johnson_legal(code_ext, N);
    idx    = IW'(johnson_to_idx(code_ext, N));
    onehot = '0;
    if (legal) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/johnson_decoder_monitor.sv
// johnson_decoder_monitor
//   Receive-side monitor for a Johnson (twisted-ring) code bus. Registers the
//   decoded index/one-hot, tracks whether the sequence advances legally, and
//   reports illegal codes and skipped states.
//   Optional feature macro: JOHNSON_DEC_BIDIR_EN (accept backward steps, drive dir).
//   Ports:
//     clk         in  1      rising-edge clock
//     clr         in  1      synchronous active-high reset, wins over en
//     en          in  1      sample strobe
//     q_in        in  N      Johnson code under test
//     idx         out IW     decoded index of the last legal sample
//     onehot      out 2N     one-hot of idx, zero after an illegal sample
//     valid       out 1      last sampled code was legal
//     locked      out 1      sequence tracking is locked
//     dir         out 1      last step was backward (0 when bidir is disabled)
//     err_illegal out 1      one-cycle pulse on an illegal sample
//     err_skip    out 1      one-cycle pulse on a bad step while locked
//     err_count   out ERR_W  saturating count of both error pulses
module johnson_decoder_monitor
  import johnson_pkg::*;
#(
  parameter int N        = 4,
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8,
  localparam int IW = $clog2(2 * N)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [N-1:0]     q_in,
  output logic [IW-1:0]    idx,
  output logic [2*N-1:0]   onehot,
  output logic             valid,
  output logic             locked,
  output logic             dir,
  output logic             err_illegal,
  output logic             err_skip,
  output logic [ERR_W-1:0] err_count
);

  localparam int STATES = 2 * N;
  localparam int RUN_W  = $clog2(LOCK_CNT + 1);

  logic             dec_legal;
  logic [IW-1:0]    dec_idx;
  logic [2*N-1:0]   dec_onehot;
  state_t           state;
  logic             ref_valid;
  logic [RUN_W-1:0] run;
  step_t            step;
  logic [IW-1:0]    next_up;
  logic             illegal_evt;
  logic             skip_evt;

  johnson_code_decode #(.N(N)) u_decode (
    .q      (q_in),
    .legal  (dec_legal),
    .idx    (dec_idx),
    .onehot (dec_onehot)
  );

  assign locked = (state == LOCKED);

`ifdef JOHNSON_DEC_BIDIR_EN
  logic [IW-1:0] next_dn;
  logic          dir_q;

  assign dir = dir_q;
`else
  assign dir = 1'b0;
`endif

  // The registered idx is the reference: it only changes on legal samples,
  // so it is always the previous legal position (when ref_valid is set).
  always_comb begin
    next_up = IW'((int'(idx) + 1) % STATES);
`ifdef JOHNSON_DEC_BIDIR_EN
    next_dn = IW'((int'(idx) + STATES - 1) % STATES);
`endif
    if (dec_idx == idx)          step = HOLD;
    else if (dec_idx == next_up) step = ADV;
`ifdef JOHNSON_DEC_BIDIR_EN
    else if (dec_idx == next_dn) step = RET;
`endif
    else                         step = SKIP;
  end

  // Error events; a skip only counts when we were locked onto a valid reference.
  always_comb begin
    illegal_evt = en && !dec_legal;
    skip_evt    = en && dec_legal && ref_valid && (state == LOCKED) && (step == SKIP);
  end

  // Output registers, tracking FSM, lock run counter and error counter.
  always_ff @(posedge clk) begin
    if (clr) begin
      idx         <= '0;
      onehot      <= '0;
      valid       <= 1'b0;
      err_illegal <= 1'b0;
      err_skip    <= 1'b0;
      err_count   <= '0;
      state       <= UNLOCKED;
      ref_valid   <= 1'b0;
      run         <= '0;
    end else begin
      err_illegal <= illegal_evt;
      err_skip    <= skip_evt;
      if ((illegal_evt || skip_evt) && err_count != '1) err_count <= err_count + 1'b1;

      if (en) begin
        if (!dec_legal) begin
          valid     <= 1'b0;
          onehot    <= '0;
          ref_valid <= 1'b0;
          state     <= UNLOCKED;
          run       <= '0;
        end else begin
          valid     <= 1'b1;
          idx       <= dec_idx;
          onehot    <= dec_onehot;
          ref_valid <= 1'b1;
          if (!ref_valid) begin
            run <= '0;
          end else if (state == UNLOCKED) begin
            case (step)
              ADV, RET: begin
                run <= run + 1'b1;
                if (int'(run) + 1 >= LOCK_CNT) state <= LOCKED;
              end
              HOLD:    run <= run;
              default: run <= '0;
            endcase
          end else if (step == SKIP) begin
            state <= UNLOCKED;
            run   <= '0;
          end
        end
      end
    end
  end

`ifdef JOHNSON_DEC_BIDIR_EN
  // Direction follows the last forward/backward step and holds otherwise.
  always_ff @(posedge clk) begin
    if (clr) begin
      dir_q <= 1'b0;
    end else if (en && dec_legal && ref_valid) begin
      if (step == ADV)      dir_q <= 1'b0;
      else if (step == RET) dir_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_johnson_decoder_monitor.sv
// tb_johnson_decoder_monitor
//   Directed bench for johnson_decoder_monitor (N=4, LOCK_CNT=3). A second
//   instance with ERR_W=2 shares all inputs to exercise counter saturation.
module tb_johnson_decoder_monitor;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       en = 1'b0;
  logic [3:0] q_in = 4'b0000;

  logic [2:0] idx;
  logic [7:0] onehot;
  logic       valid, locked, dir, err_illegal, err_skip;
  logic [7:0] err_count;

  logic [2:0] s_idx;
  logic [7:0] s_onehot;
  logic       s_valid, s_locked, s_dir, s_err_illegal, s_err_skip;
  logic [1:0] s_err_count;

  int total = 0;
  int bad = 0;
  int ecnt = 0;

  johnson_decoder_monitor #(.N(4), .LOCK_CNT(3), .ERR_W(8)) dut (
    .clk(clk), .clr(clr), .en(en), .q_in(q_in),
    .idx(idx), .onehot(onehot), .valid(valid), .locked(locked), .dir(dir),
    .err_illegal(err_illegal), .err_skip(err_skip), .err_count(err_count)
  );

  johnson_decoder_monitor #(.N(4), .LOCK_CNT(3), .ERR_W(2)) dut_sat (
    .clk(clk), .clr(clr), .en(en), .q_in(q_in),
    .idx(s_idx), .onehot(s_onehot), .valid(s_valid), .locked(s_locked), .dir(s_dir),
    .err_illegal(s_err_illegal), .err_skip(s_err_skip), .err_count(s_err_count)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one sample between edges, then look just after the capturing edge.
  task automatic applyStimulus(input logic [3:0] code, input logic e);
    @(negedge clk);
    clr  = 1'b0;
    en   = e;
    q_in = code;
    @(posedge clk);
    #1;
  endtask

  task automatic checkAll(input string tag, input int e_idx, input int e_oh, input int e_valid,
                          input int e_locked, input int e_ill, input int e_skip);
    checkOutput({tag, " idx"}, 32'(idx), 32'(e_idx));
    checkOutput({tag, " onehot"}, 32'(onehot), 32'(e_oh));
    checkOutput({tag, " valid"}, 32'(valid), 32'(e_valid));
    checkOutput({tag, " locked"}, 32'(locked), 32'(e_locked));
    checkOutput({tag, " err_illegal"}, 32'(err_illegal), 32'(e_ill));
    checkOutput({tag, " err_skip"}, 32'(err_skip), 32'(e_skip));
    checkOutput({tag, " err_count"}, 32'(err_count), 32'(ecnt));
    checkOutput({tag, " sat_count"}, 32'(s_err_count), 32'((ecnt > 3) ? 3 : ecnt));
  endtask

  logic [3:0] ill_codes [5] = '{4'b0101, 4'b0010, 4'b0100, 4'b1010, 4'b1101};

  initial begin
    // Reset held for two cycles
    @(negedge clk);
    clr = 1'b1;
    en  = 1'b1;
    q_in = 4'b0111;
    repeat (2) @(posedge clk);
    #1;
    checkAll("reset", 0, 0, 0, 0, 0, 0);
    checkOutput("reset dir", 32'(dir), 32'd0);

    // Forward sequence locks on the third advance
    applyStimulus(4'b0000, 1'b1); checkAll("seq0", 0, 8'h01, 1, 0, 0, 0);
    applyStimulus(4'b0001, 1'b1); checkAll("seq1", 1, 8'h02, 1, 0, 0, 0);
    applyStimulus(4'b0011, 1'b1); checkAll("seq2", 2, 8'h04, 1, 0, 0, 0);
    applyStimulus(4'b0111, 1'b1); checkAll("seq3", 3, 8'h08, 1, 1, 0, 0);

    // Illegal code while locked
    ecnt = 1;
    applyStimulus(4'b0101, 1'b1); checkAll("illegal", 3, 0, 0, 0, 1, 0);
    applyStimulus(4'b1111, 1'b0); checkAll("en0 hold", 3, 0, 0, 0, 0, 0);

    // Relock at 0011 via 1000 seed, then jump to 1110
    applyStimulus(4'b1000, 1'b1); checkAll("seed7", 7, 8'h80, 1, 0, 0, 0);
    applyStimulus(4'b0000, 1'b1); checkAll("wrap adv", 0, 8'h01, 1, 0, 0, 0);
    applyStimulus(4'b0001, 1'b1); checkAll("adv1", 1, 8'h02, 1, 0, 0, 0);
    applyStimulus(4'b0011, 1'b1); checkAll("lock2", 2, 8'h04, 1, 1, 0, 0);
    ecnt = 2;
    applyStimulus(4'b1110, 1'b1); checkAll("skip5", 5, 8'h20, 1, 0, 0, 1);

    // Unlocked skip reseeds silently, then relock and step backward
    applyStimulus(4'b1000, 1'b1); checkAll("silent skip", 7, 8'h80, 1, 0, 0, 0);
    applyStimulus(4'b0000, 1'b1); checkAll("rl0", 0, 8'h01, 1, 0, 0, 0);
    applyStimulus(4'b0001, 1'b1); checkAll("rl1", 1, 8'h02, 1, 0, 0, 0);
    applyStimulus(4'b0011, 1'b1); checkAll("rl2", 2, 8'h04, 1, 1, 0, 0);
`ifdef JOHNSON_DEC_BIDIR_EN
    applyStimulus(4'b0001, 1'b1); checkAll("ret", 1, 8'h02, 1, 1, 0, 0);
    checkOutput("ret dir", 32'(dir), 32'd1);
`else
    ecnt = 3;
    applyStimulus(4'b0001, 1'b1); checkAll("ret skip", 1, 8'h02, 1, 0, 0, 1);
    checkOutput("ret dir", 32'(dir), 32'd0);
`endif

    // Lock again going forward, then wrap through 7 -> 0
    applyStimulus(4'b0011, 1'b1); checkAll("f2", 2, 8'h04, 1, `ifdef JOHNSON_DEC_BIDIR_EN 1 `else 0 `endif, 0, 0);
    checkOutput("adv dir", 32'(dir), 32'd0);
    applyStimulus(4'b0111, 1'b1);
    applyStimulus(4'b1111, 1'b1); checkAll("f4", 4, 8'h10, 1, 1, 0, 0);
    applyStimulus(4'b1110, 1'b1); checkAll("w5", 5, 8'h20, 1, 1, 0, 0);
    applyStimulus(4'b1100, 1'b1); checkAll("w6", 6, 8'h40, 1, 1, 0, 0);
    applyStimulus(4'b1000, 1'b1); checkAll("w7", 7, 8'h80, 1, 1, 0, 0);
    applyStimulus(4'b0000, 1'b1); checkAll("w0", 0, 8'h01, 1, 1, 0, 0);
    applyStimulus(4'b0001, 1'b1); checkAll("w1", 1, 8'h02, 1, 1, 0, 0);
    applyStimulus(4'b0001, 1'b1); checkAll("hold", 1, 8'h02, 1, 1, 0, 0);
    applyStimulus(4'b1111, 1'b0); checkAll("en0 locked", 1, 8'h02, 1, 1, 0, 0);

    // Five illegal codes saturate the 2-bit counter
    for (int i = 0; i < 5; i++) begin
      ecnt++;
      applyStimulus(ill_codes[i], 1'b1);
      checkAll($sformatf("ill%0d", i), 1, 0, 0, 0, 1, 0);
    end
    checkOutput("saturated", 32'(s_err_count), 32'd3);

    // Clear mid-sequence, with en=1 and an illegal code present
    applyStimulus(4'b0111, 1'b1); checkAll("pre clr", 3, 8'h08, 1, 0, 0, 0);
    @(negedge clk);
    clr  = 1'b1;
    en   = 1'b1;
    q_in = 4'b0101;
    @(posedge clk);
    #1;
    ecnt = 0;
    checkAll("clr", 0, 0, 0, 0, 0, 0);
    checkOutput("clr dir", 32'(dir), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
